// File: rtl/common.sv
// Shared constants and types for the boot path: UART framing, program memory geometry, loader states.
// Compile-time only, no logic.
package common;
  localparam logic RESET = 1'b0;

  localparam int FREQUENCY_IN_HZ       = 1_843_200;
  localparam int BAUD_RATE             = 115_200;
  localparam int BAUD_COUNT_CHECK      = FREQUENCY_IN_HZ / BAUD_RATE;
  localparam int NUM_DATA_BITS         = 8;
  localparam int INSTRUCTION_WIDTH     = 32;
  localparam int PROGRAM_ADDRESS_WIDTH = 8;

  // beq x0, x0, 0 : parks the core once the loaded image falls off its end
  localparam logic [INSTRUCTION_WIDTH-1:0] INF_LOOP      = 32'h0000_0063;
  localparam logic [NUM_DATA_BITS-1:0]     LOADER_HEADER = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    CHECK,
    TERM,
    RUN,
    ERROR
  } loader_state_type;
endpackage

// File: rtl/loader_gap_timer.sv
// Inter-byte gap timer: counts cycles since the last clear while enabled, flags when LIMIT is reached.
// Latency: expired is a combinational decode of the count register; clear takes effect next cycle.
// Backpressure: none.
module loader_gap_timer
  import common::*;
#(
  parameter int LIMIT = 20 * BAUD_COUNT_CHECK
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic expired
);
  localparam int W = $clog2(LIMIT + 1);
  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  // cnt holds the number of cycles elapsed since the clearing cycle, so the
  // cycle in which expired is seen is LIMIT-1 cycles after the last clear
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= W'(1);
    end else if (!en) begin
      cnt <= '0;
    end else if (cnt != LAST) begin
      cnt <= cnt + W'(1);
    end
  end

  assign expired = en && !clr && (cnt == LAST);
endmodule

// File: rtl/uart_program_loader.sv
// Boot loader: frames UART bytes into words and writes instruction memory, holding the core in reset until done; LOADER_CHECKSUM_EN adds an XOR trailer byte.
// Latency: each word is written the cycle after its 4th byte; core released the cycle after the terminator write.
// Backpressure: none, one byte per cycle is always accepted.
module uart_program_loader
  import common::*;
#(
  parameter logic [NUM_DATA_BITS-1:0] HEADER = LOADER_HEADER,
  parameter int MAX_WORDS      = 2 ** (PROGRAM_ADDRESS_WIDTH - 2),
  parameter int TIMEOUT_CYCLES = 20 * BAUD_COUNT_CHECK
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             rx_valid,
  input  logic [NUM_DATA_BITS-1:0]         rx_data,
  output logic                             imem_we,
  output logic [PROGRAM_ADDRESS_WIDTH-1:0] imem_addr,
  output logic [INSTRUCTION_WIDTH-1:0]     imem_wdata,
  output logic                             core_reset,
  output logic                             busy,
  output logic                             error
);
  localparam int CW = NUM_DATA_BITS + 1;
  localparam logic [CW-1:0] MAX_N = CW'(MAX_WORDS);

  loader_state_type                 state;
  logic [NUM_DATA_BITS-1:0]         count;
  logic [NUM_DATA_BITS-1:0]         word_idx;
  logic [1:0]                       byte_idx;
  logic [23:0]                      asm_word;
  logic                             timing;
  logic                             gap_expired;
  logic                             words_done;
  logic                             term_we;
  logic [PROGRAM_ADDRESS_WIDTH-1:0] term_addr;
`ifdef LOADER_CHECKSUM_EN
  logic [NUM_DATA_BITS-1:0]         csum;
  logic                             last_word;

  assign last_word = (word_idx == count - NUM_DATA_BITS'(1));
`endif

  assign timing     = (state == COUNT) || (state == DATA) || (state == CHECK);
  assign words_done = (word_idx == count);
  // a full image leaves no room for the terminator
  assign term_we    = ({1'b0, count} < MAX_N);
  assign term_addr  = {count[PROGRAM_ADDRESS_WIDTH-3:0], 2'b00};

  loader_gap_timer #(
    .LIMIT(TIMEOUT_CYCLES)
  ) u_gap (
    .clk    (clk),
    .reset  (reset),
    .en     (timing),
    .clr    (rx_valid),
    .expired(gap_expired)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (reset == RESET) begin
      state      <= IDLE;
      count      <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      asm_word   <= '0;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        IDLE, RUN, ERROR: begin
          if (rx_valid && rx_data == HEADER) state <= COUNT;
        end
        COUNT: begin
          if (rx_valid) begin
            count    <= rx_data;
            word_idx <= '0;
            byte_idx <= '0;
            asm_word <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum     <= '0;
`endif
            if ({1'b0, rx_data} > MAX_N) begin
              state <= ERROR;
            end else if (rx_data == '0) begin
`ifdef LOADER_CHECKSUM_EN
              state <= CHECK;
`else
              state      <= TERM;
              imem_we    <= 1'b1;
              imem_addr  <= '0;
              imem_wdata <= INF_LOOP;
`endif
            end else begin
              state <= DATA;
            end
          end else if (gap_expired) begin
            state <= ERROR;
          end
        end
        DATA: begin
          if (rx_valid && !words_done) begin
            byte_idx <= byte_idx + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            csum     <= csum ^ rx_data;
`endif
            case (byte_idx)
              2'd0: asm_word[7:0]   <= rx_data;
              2'd1: asm_word[15:8]  <= rx_data;
              2'd2: asm_word[23:16] <= rx_data;
              2'd3: begin
                imem_we    <= 1'b1;
                imem_addr  <= {word_idx[PROGRAM_ADDRESS_WIDTH-3:0], 2'b00};
                imem_wdata <= {rx_data, asm_word};
                word_idx   <= word_idx + NUM_DATA_BITS'(1);
`ifdef LOADER_CHECKSUM_EN
                if (last_word) state <= CHECK;
`endif
              end
            endcase
`ifndef LOADER_CHECKSUM_EN
          // the last data write occupies this cycle, so the terminator follows in TERM
          end else if (words_done) begin
            state      <= TERM;
            imem_we    <= term_we;
            imem_addr  <= term_addr;
            imem_wdata <= INF_LOOP;
`endif
          end else if (gap_expired) begin
            state <= ERROR;
          end
        end
`ifdef LOADER_CHECKSUM_EN
        CHECK: begin
          if (rx_valid) begin
            if (rx_data == csum) begin
              state      <= TERM;
              imem_we    <= term_we;
              imem_addr  <= term_addr;
              imem_wdata <= INF_LOOP;
            end else begin
              state <= ERROR;
            end
          end else if (gap_expired) begin
            state <= ERROR;
          end
        end
`endif
        TERM:    state <= RUN;
        default: state <= IDLE;
      endcase
    end
  end

  assign busy       = (state == COUNT) || (state == DATA) || (state == CHECK) || (state == TERM);
  assign error      = (state == ERROR);
  assign core_reset = (state == RUN) ? ~RESET : RESET;
endmodule

// File: tb/tb_uart_program_loader.sv
// Randomized scoreboard bench for uart_program_loader; frame model builds expected writes from image words.
module tb_uart_program_loader;
  import common::*;

  localparam int TMO  = 20 * BAUD_COUNT_CHECK;
  localparam int MAXW = 64;
  localparam logic [7:0]  HDR       = 8'hA5;
  localparam logic [31:0] TERM_WORD = 32'h0000_0063;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
    logic        term;
  } wr_t;

  logic        clk;
  logic        reset;
  logic        rx_valid;
  logic [7:0]  rx_data;
  logic        imem_we;
  logic [7:0]  imem_addr;
  logic [31:0] imem_wdata;
  logic        core_reset;
  logic        busy;
  logic        error;

  wr_t         exp_q[$];
  logic [31:0] img[MAXW];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          last_term_cyc = -100;

  uart_program_loader dut (
    .clk       (clk),
    .reset     (reset),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .imem_we   (imem_we),
    .imem_addr (imem_addr),
    .imem_wdata(imem_wdata),
    .core_reset(core_reset),
    .busy      (busy),
    .error     (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endtask

  task automatic push_exp(input logic [7:0] a, input logic [31:0] d, input logic t);
    wr_t w;
    w.addr = a;
    w.data = d;
    w.term = t;
    exp_q.push_back(w);
  endtask

  // Reference: every image word lands at 4*i; a complete, accepted image gets
  // the terminator right after the last word unless memory is full.
  task automatic expect_image(input int n, input bit ok);
    if (n > MAXW) return;
    for (int i = 0; i < n; i++) push_exp(8'(i * 4), img[i], 1'b0);
    if (ok && n < MAXW) push_exp(8'(n * 4), TERM_WORD, 1'b1);
  endtask

  task automatic fill_img(input int n);
    for (int i = 0; i < n; i++) img[i] = $urandom;
  endtask

  // Caller is aligned to a negedge; returns on a negedge.
  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  function automatic int pick_gap(input int gap);
    return (gap < 0) ? int'($urandom_range(0, 2)) : gap;
  endfunction

  // Count, data and optional trailer; no idle cycles after the final byte.
  task automatic send_body(input int n, input bit bad_csum, input int gap);
    logic [7:0] x;
    logic [7:0] b;
    bit         has_tail;
    x = 8'h00;
`ifdef LOADER_CHECKSUM_EN
    has_tail = 1'b1;
`else
    has_tail = 1'b0;
`endif
    if (n > MAXW || (n == 0 && !has_tail)) begin
      send_byte(8'(n), 0);
      return;
    end
    send_byte(8'(n), pick_gap(gap));
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < 4; k++) begin
        b = img[i][8*k +: 8];
        x = x ^ b;
        send_byte(b, (i == n - 1 && k == 3 && !has_tail) ? 0 : pick_gap(gap));
      end
    end
    if (has_tail) send_byte(bad_csum ? ~x : x, 0);
  endtask

  task automatic wait_run(input bit with_term);
    int k;
    k = 0;
    while (!core_reset && k < 60) begin
      @(negedge clk);
      k++;
    end
    check("core_reset_release", core_reset, 1);
    check("busy_in_run", busy, 0);
    if (with_term) check("release_after_term", cyc - last_term_cyc, 1);
  endtask

  task automatic drain();
    repeat (4) @(negedge clk);
    check("writes_drained", exp_q.size(), 0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_imem_we"}, imem_we, 0);
    check({tag, "_imem_addr"}, imem_addr, 0);
    check({tag, "_imem_wdata"}, imem_wdata, 0);
    check({tag, "_core_reset"}, core_reset, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_error"}, error, 0);
  endtask

  // Monitor: every write strobe must match the oldest expected write.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (reset && imem_we) begin
        check("write_expected", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("imem_addr", imem_addr, e.addr);
          check("imem_wdata", imem_wdata, e.data);
          if (e.term) last_term_cyc = cyc;
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    reset    = 1'b0;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clk);

    // reference image from the bring-up program
    img[0] = 32'h0000_0013;
    img[1] = 32'h0010_0093;
    expect_image(2, 1'b1);
    send_byte(HDR, 0);
    send_body(2, 1'b0, 0);
    wait_run(1'b1);
    drain();

    // RUN ignores ordinary bytes; a header pulls the core back into reset
    send_byte(8'h13, 2);
    check("run_ignores_byte", core_reset, 1);
    send_byte(HDR, 0);
    check("restart_core_reset", core_reset, 0);
    check("restart_busy", busy, 1);

    // empty image: terminator only
    expect_image(0, 1'b1);
    send_body(0, 1'b0, 0);
    wait_run(1'b1);
    drain();

    for (int t = 0; t < 4; t++) begin
      n = $urandom_range(1, MAXW - 1);
      fill_img(n);
      expect_image(n, 1'b1);
      send_byte(HDR, $urandom_range(0, 2));
      send_body(n, 1'b0, -1);
      wait_run(1'b1);
      drain();
    end

    // full memory: no terminator
    fill_img(MAXW);
    expect_image(MAXW, 1'b1);
    send_byte(HDR, 0);
    send_body(MAXW, 1'b0, -1);
    wait_run(1'b0);
    drain();

    // oversize count
    send_byte(HDR, 0);
    send_body(MAXW + 1, 1'b0, 0);
    repeat (2) @(negedge clk);
    check("oversize_error", error, 1);
    check("oversize_core_reset", core_reset, 0);
    drain();

`ifdef LOADER_CHECKSUM_EN
    fill_img(3);
    expect_image(3, 1'b0);
    send_byte(HDR, 0);
    send_body(3, 1'b1, 0);
    repeat (2) @(negedge clk);
    check("bad_csum_error", error, 1);
    check("bad_csum_core_reset", core_reset, 0);
    drain();
`endif

    // timeout after 5 data bytes: one word already written
    fill_img(2);
    push_exp(8'h00, img[0], 1'b0);
    send_byte(HDR, 0);
    send_byte(8'd2, 0);
    for (int k = 0; k < 5; k++) send_byte((k < 4) ? img[0][8*k +: 8] : img[1][7:0], 0);
    n = 1;
    while (!error && n < TMO + 20) begin
      @(negedge clk);
      n++;
    end
    check("timeout_cycles", n, TMO);
    check("timeout_core_reset", core_reset, 0);

    // header recovers from ERROR
    send_byte(HDR, 0);
    check("recover_busy", busy, 1);
    check("recover_error", error, 0);
    fill_img(1);
    expect_image(1, 1'b1);
    send_body(1, 1'b0, 0);
    wait_run(1'b1);
    drain();

    // longest gap that must not time out
    fill_img(1);
    expect_image(1, 1'b1);
    send_byte(HDR, TMO - 2);
    send_body(1, 1'b0, TMO - 2);
    wait_run(1'b1);
    drain();

    // reset in the middle of DATA
    fill_img(3);
    push_exp(8'h00, img[0], 1'b0);
    send_byte(HDR, 0);
    send_byte(8'd3, 0);
    for (int k = 0; k < 6; k++) send_byte(img[k / 4][8*(k % 4) +: 8], 0);
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midrst_queue", exp_q.size(), 0);
    fill_img(2);
    expect_image(2, 1'b1);
    send_byte(HDR, 1);
    send_body(2, 1'b0, -1);
    wait_run(1'b1);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
